port_peer_device: RTL and testbench

PORT_PEER_DEVICE -- requirements
Module: port_peer_device

---
 rtl/port_peer_device_pkg.sv | 11 +
 rtl/port_peer_device_sync_fifo.sv | 54 +++++
 rtl/port_peer_device.sv | 91 +++++++++
 tb/tb_port_peer_device.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/port_peer_device_pkg.sv
// Shared state encoding and default FIFO depth for the IO-port peer device.
package globe;
    localparam int PEER_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        TURN    = 2'd2,
        DRIVE   = 2'd3
    } PEER_STATE_T;
endpackage

// File: rtl/port_peer_device_sync_fifo.sv
// Small synchronous FIFO with zero-latency head output (reads 0 when empty).
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok)
            count_d = count_q - CW'(1);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/port_peer_device.sv
// Peer on a bidirectional processor IO port: captures bytes the processor writes
// and serves response bytes when the processor reads.
module port_peer_device
    import globe::*;
#(
    parameter int DEPTH = PEER_DEPTH_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    inout  wire  [7:0] IO,
    input  logic       HOST_DIR,
    input  logic       HOST_STB,
    output logic [7:0] CAP_DATA,
    output logic       CAP_VALID,
    input  logic       CAP_READY,
    input  logic [7:0] RSP_DATA,
    input  logic       RSP_VALID,
    output logic       RSP_READY,
    output logic       OVERRUN,
    output logic       UNDERRUN,
    input  logic       CLR_ERR
);
    PEER_STATE_T state_q;
    logic        overrun_q, underrun_q;
    logic        cap_push, cap_pop, cap_full, cap_empty;
    logic        rsp_push, rsp_pop_req, rsp_full, rsp_empty;
    logic [7:0]  rsp_head;
    logic        drive_en, overrun_set, underrun_set;

    // Release is combinational on HOST_DIR so the bus is freed the cycle the host turns it.
    assign drive_en     = (state_q == DRIVE) && !HOST_DIR;
    assign IO           = drive_en ? rsp_head : 8'hzz;

    assign cap_push     = (state_q == CAPTURE) && HOST_STB;
    assign cap_pop      = CAP_READY && CAP_VALID;
    assign overrun_set  = cap_push && cap_full && !cap_pop;

    assign rsp_push     = RSP_VALID && !rsp_full;
    assign rsp_pop_req  = (state_q == DRIVE) && HOST_STB;
    assign underrun_set = rsp_pop_req && rsp_empty;

    assign CAP_VALID    = !cap_empty;
    assign RSP_READY    = !rsp_full;
    assign OVERRUN      = overrun_q;
    assign UNDERRUN     = underrun_q;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_cap_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .push_i  (cap_push),
        .data_i  (IO),
        .pop_i   (cap_pop),
        .data_o  (CAP_DATA),
        .full_o  (cap_full),
        .empty_o (cap_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .push_i  (rsp_push),
        .data_i  (RSP_DATA),
        .pop_i   (rsp_pop_req),
        .data_o  (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE:    state_q <= HOST_DIR ? CAPTURE : TURN;
                CAPTURE: state_q <= HOST_DIR ? CAPTURE : TURN;
                TURN:    state_q <= HOST_DIR ? CAPTURE : DRIVE;
                DRIVE:   state_q <= HOST_DIR ? CAPTURE : DRIVE;
                default: state_q <= IDLE;
            endcase

            // An error event in the same cycle as CLR_ERR keeps the flag set.
            if (overrun_set)  overrun_q <= 1'b1;
            else if (CLR_ERR) overrun_q <= 1'b0;

            if (underrun_set) underrun_q <= 1'b1;
            else if (CLR_ERR) underrun_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_port_peer_device.sv
// Directed bench for port_peer_device: a vector table for the main flow plus
// hand-written sequences for full-FIFO, response-FIFO and mid-drive reset corners.
module tb_port_peer_device;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       host_oe;
    logic [7:0] host_io;
    logic       host_dir, host_stb, cap_ready, rsp_valid, clr_err;
    logic [7:0] rsp_data;
    logic [7:0] cap_data;
    logic       cap_valid, rsp_ready, overrun, underrun;
    wire  [7:0] io_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Pull-ups make a released bus read as 8'hFF.
    assign io_bus = host_oe ? host_io : 8'hzz;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pull
            pullup (io_bus[gi]);
        end
    endgenerate

    port_peer_device #(.DEPTH(4)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .IO        (io_bus),
        .HOST_DIR  (host_dir),
        .HOST_STB  (host_stb),
        .CAP_DATA  (cap_data),
        .CAP_VALID (cap_valid),
        .CAP_READY (cap_ready),
        .RSP_DATA  (rsp_data),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .OVERRUN   (overrun),
        .UNDERRUN  (underrun),
        .CLR_ERR   (clr_err)
    );

    typedef struct {
        logic       dir, oe, stb;
        logic [7:0] io;
        logic       crdy, rvld;
        logic [7:0] rdat;
        logic       clr;
        logic       e_cv;
        logic [7:0] e_cd;
        logic       e_rr;
        logic [7:0] e_io;
        logic       e_ov, e_ud;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_oe = L; host_io = 8'h00; host_dir = L; host_stb = L;
        cap_ready = L; rsp_valid = L; rsp_data = 8'h00; clr_err = L;
    endtask

    initial begin
        idle_inputs();
        rst_n = L;

        //           dir oe stb io     crdy rvld rdat   clr  cv cd     rr eio    ov ud
        vq.push_back('{H, L, L, 8'h00, L, L, 8'h00, L,  L, 8'h00, H, 8'hFF, L, L});
        vq.push_back('{H, H, H, 8'hA5, L, L, 8'h00, L,  H, 8'hA5, H, 8'hA5, L, L});
        vq.push_back('{H, L, L, 8'h00, H, L, 8'h00, L,  L, 8'h00, H, 8'hFF, L, L});
        vq.push_back('{H, L, L, 8'h00, L, H, 8'h11, L,  L, 8'h00, H, 8'hFF, L, L});
        vq.push_back('{H, L, L, 8'h00, L, H, 8'h22, L,  L, 8'h00, H, 8'hFF, L, L});
        vq.push_back('{L, L, L, 8'h00, L, L, 8'h00, L,  L, 8'h00, H, 8'hFF, L, L});
        vq.push_back('{L, L, L, 8'h00, L, L, 8'h00, L,  L, 8'h00, H, 8'h11, L, L});
        vq.push_back('{L, L, H, 8'h00, L, L, 8'h00, L,  L, 8'h00, H, 8'h22, L, L});
        vq.push_back('{L, L, H, 8'h00, L, L, 8'h00, L,  L, 8'h00, H, 8'h00, L, L});
        vq.push_back('{L, L, H, 8'h00, L, L, 8'h00, H,  L, 8'h00, H, 8'h00, L, H});
        vq.push_back('{L, L, L, 8'h00, L, L, 8'h00, H,  L, 8'h00, H, 8'h00, L, L});
        vq.push_back('{H, L, L, 8'h00, L, L, 8'h00, L,  L, 8'h00, H, 8'hFF, L, L});
        vq.push_back('{H, H, H, 8'hB0, L, L, 8'h00, L,  H, 8'hB0, H, 8'hB0, L, L});
        vq.push_back('{H, H, H, 8'hB1, L, L, 8'h00, L,  H, 8'hB0, H, 8'hB1, L, L});
        vq.push_back('{H, H, H, 8'hB2, L, L, 8'h00, L,  H, 8'hB0, H, 8'hB2, L, L});
        vq.push_back('{H, H, H, 8'hB3, L, L, 8'h00, L,  H, 8'hB0, H, 8'hB3, L, L});
        vq.push_back('{H, H, H, 8'hB4, L, L, 8'h00, L,  H, 8'hB0, H, 8'hB4, H, L});
        vq.push_back('{H, L, L, 8'h00, L, L, 8'h00, H,  H, 8'hB0, H, 8'hFF, L, L});
        vq.push_back('{H, L, L, 8'h00, H, L, 8'h00, L,  H, 8'hB1, H, 8'hFF, L, L});
        vq.push_back('{H, L, L, 8'h00, H, L, 8'h00, L,  H, 8'hB2, H, 8'hFF, L, L});
        vq.push_back('{H, L, L, 8'h00, H, L, 8'h00, L,  H, 8'hB3, H, 8'hFF, L, L});
        vq.push_back('{H, L, L, 8'h00, H, L, 8'h00, L,  L, 8'h00, H, 8'hFF, L, L});

        // Reset state
        step();
        step();
        check("rst_cap_valid", {7'd0, cap_valid}, 8'h00);
        check("rst_cap_data", cap_data, 8'h00);
        check("rst_rsp_ready", {7'd0, rsp_ready}, 8'h01);
        check("rst_io", io_bus, 8'hFF);
        check("rst_overrun", {7'd0, overrun}, 8'h00);
        check("rst_underrun", {7'd0, underrun}, 8'h00);
        rst_n = H;

        foreach (vq[i]) begin
            host_dir = vq[i].dir; host_oe = vq[i].oe; host_stb = vq[i].stb;
            host_io = vq[i].io; cap_ready = vq[i].crdy; rsp_valid = vq[i].rvld;
            rsp_data = vq[i].rdat; clr_err = vq[i].clr;
            step();
            $display("vec %0d dir=%b stb=%b io=%h -> cap=%b/%h rsp_rdy=%b bus=%h ovr=%b udr=%b",
                     i, host_dir, host_stb, host_io, cap_valid, cap_data, rsp_ready,
                     io_bus, overrun, underrun);
            check($sformatf("v%0d_cap_valid", i), {7'd0, cap_valid}, {7'd0, vq[i].e_cv});
            check($sformatf("v%0d_cap_data", i), cap_data, vq[i].e_cd);
            check($sformatf("v%0d_rsp_ready", i), {7'd0, rsp_ready}, {7'd0, vq[i].e_rr});
            check($sformatf("v%0d_io", i), io_bus, vq[i].e_io);
            check($sformatf("v%0d_overrun", i), {7'd0, overrun}, {7'd0, vq[i].e_ov});
            check($sformatf("v%0d_underrun", i), {7'd0, underrun}, {7'd0, vq[i].e_ud});
        end
        idle_inputs();
        host_dir = H;

        // Full capture FIFO: push with same-cycle pop keeps count at 4
        for (int k = 0; k < 4; k++) begin
            host_oe = H; host_stb = H; host_io = 8'hC0 + 8'(k);
            step();
        end
        host_io = 8'h5C; cap_ready = H;
        step();
        $display("seq full_push_pop ovr=%b head=%h", overrun, cap_data);
        check("fpp_overrun", {7'd0, overrun}, 8'h00);
        check("fpp_head", cap_data, 8'hC1);
        host_io = 8'h5D; cap_ready = L;
        step();
        $display("seq still_full ovr=%b", overrun);
        check("fpp_still_full", {7'd0, overrun}, 8'h01);
        host_stb = L; host_oe = L; clr_err = H;
        step();
        clr_err = L;
        check("fpp_clr", {7'd0, overrun}, 8'h00);
        begin
            logic [7:0] drain [4];
            drain = '{8'hC1, 8'hC2, 8'hC3, 8'h5C};
            for (int k = 0; k < 4; k++) begin
                $display("seq drain %0d head=%h", k, cap_data);
                check($sformatf("drain%0d_valid", k), {7'd0, cap_valid}, 8'h01);
                check($sformatf("drain%0d_data", k), cap_data, drain[k]);
                cap_ready = H;
                step();
                cap_ready = L;
            end
        end
        check("drain_empty", {7'd0, cap_valid}, 8'h00);

        // Response FIFO: push+pop on empty pushes only; full blocks pushes
        host_dir = L;
        step();
        check("b_turn_io", io_bus, 8'hFF);
        step();
        check("b_drive_empty_io", io_bus, 8'h00);
        host_stb = H; rsp_valid = H; rsp_data = 8'h77;
        step();
        host_stb = L; rsp_valid = L;
        $display("seq empty_push_pop bus=%h udr=%b", io_bus, underrun);
        check("b_push_only_io", io_bus, 8'h77);
        check("b_push_only_udr", {7'd0, underrun}, 8'h01);
        clr_err = H;
        step();
        clr_err = L;
        check("b_clr_udr", {7'd0, underrun}, 8'h00);
        for (int k = 0; k < 3; k++) begin
            rsp_valid = H; rsp_data = 8'h88 + 8'(k * 17);
            step();
        end
        rsp_valid = L;
        check("b_full_ready", {7'd0, rsp_ready}, 8'h00);
        host_stb = H; rsp_valid = H; rsp_data = 8'hEE;
        step();
        rsp_valid = L;
        check("b_pop_io", io_bus, 8'h88);
        check("b_pop_ready", {7'd0, rsp_ready}, 8'h01);
        step();
        check("b_pop2_io", io_bus, 8'h99);
        step();
        check("b_pop3_io", io_bus, 8'hAA);
        step();
        host_stb = L;
        $display("seq rsp_drained bus=%h udr=%b", io_bus, underrun);
        check("b_drained_io", io_bus, 8'h00);
        check("b_drained_udr", {7'd0, underrun}, 8'h00);

        // Reset asserted mid-drive releases IO and empties both FIFOs at once
        host_dir = H;
        step();
        host_oe = H; host_io = 8'h44; host_stb = H;
        step();
        host_oe = L; host_stb = L; rsp_valid = H; rsp_data = 8'h33;
        step();
        rsp_valid = L; host_dir = L;
        step();
        step();
        check("c_drive_io", io_bus, 8'h33);
        check("c_cap_valid", {7'd0, cap_valid}, 8'h01);
        #2;
        rst_n = L;
        #1;
        $display("seq async_reset bus=%h cap=%b rsp_rdy=%b", io_bus, cap_valid, rsp_ready);
        check("c_rst_io", io_bus, 8'hFF);
        check("c_rst_cap_valid", {7'd0, cap_valid}, 8'h00);
        check("c_rst_cap_data", cap_data, 8'h00);
        check("c_rst_rsp_ready", {7'd0, rsp_ready}, 8'h01);
        step();
        rst_n = H;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
